// File: rtl/inst_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue.
package inst_queue_pkg;

  // The IF->ID beat width: 64 bits ({inst, pc}).
  localparam int IQ_WIDTH_DEFAULT = 64;

  localparam int IQ_DEPTH_DEFAULT = 4;

  // Layout of one IF->ID beat.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if2id_t;

  // Occupancy width for a queue of the given depth (0..depth inclusive).
  function automatic int iq_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iq_ram.sv
// Queue storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the pointer logic never exposes an
// entry that has not been written since the last reset/flush.
module iq_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the incoming beat into its slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a small circular FIFO with
// flush/branch redirect clearing and a head entry presented to the decoder.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int WIDTH = IQ_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       br_taken,
  input  logic                       if_to_id_valid,
  input  logic [WIDTH-1:0]           if_to_id_zip,
  output logic                       id_allowin,
  output logic                       iq_valid,
  output logic [WIDTH-1:0]           iq_zip,
  input  logic                       dec_allowin,
  output logic [$clog2(DEPTH):0]     iq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = iq_count_width(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic kill;
  logic push;
  logic pop;

  // Either redirect source empties the queue; a flush and a branch have the
  // same effect, so they are simply merged.
  assign kill = flush | br_taken;

  // Acceptance depends only on registered occupancy, never on dec_allowin,
  // so a slot freed by a pop is offered to IF one cycle later.
  assign id_allowin = resetn & (count_q != CW'(DEPTH));
  assign iq_valid   = resetn & (count_q != '0) & ~kill;

  assign push = if_to_id_valid & id_allowin & ~kill;
  assign pop  = iq_valid & dec_allowin;

  assign iq_count = count_q;

  // Next-state pointers and occupancy; redirect returns everything to zero.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (kill) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Register pointers and occupancy with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Head entry is read asynchronously at the read pointer; a beat written
  // this cycle becomes visible only after the write edge, so no bypass.
  iq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_iq_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (if_to_id_zip),
    .raddr_i (rptr_q),
    .rdata_o (iq_zip)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: table-driven fill/drain plus
// hand-written streaming, wrap, flush, branch and reset sequences, with a
// scoreboard supplying the expected head payloads.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 64;

  logic             clk;
  logic             resetn;
  logic             flush;
  logic             br_taken;
  logic             if_to_id_valid;
  logic [WIDTH-1:0] if_to_id_zip;
  logic             id_allowin;
  logic             iq_valid;
  logic [WIDTH-1:0] iq_zip;
  logic             dec_allowin;
  logic [$clog2(DEPTH):0] iq_count;

  inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .br_taken       (br_taken),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_zip   (if_to_id_zip),
    .id_allowin     (id_allowin),
    .iq_valid       (iq_valid),
    .iq_zip         (iq_zip),
    .dec_allowin    (dec_allowin),
    .iq_count       (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Scoreboard and reference occupancy.
  logic [WIDTH-1:0] sb[$];
  int               m_count = 0;

  // Observations from the most recent step.
  logic obs_allow, obs_valid;
  int   obs_count;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        dec;
    logic        exp_allow;
    logic        exp_valid;
    int          exp_count;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      checks_passed++;
    end
  endtask

  function automatic logic [WIDTH-1:0] mk_zip(input logic [31:0] pc);
    if2id_t b;
    b.inst = ~pc ^ 32'h0bad_f00d;
    b.pc   = pc;
    return b;
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the reference model, then let the rising edge commit.
  task automatic step(input logic v, input logic [31:0] pc, input logic dec,
                      input logic fl, input logic br, input logic rn);
    logic m_allow, m_valid, m_push, m_pop;
    logic [WIDTH-1:0] exp_zip;
    @(negedge clk);
    if_to_id_valid = v;
    if_to_id_zip   = mk_zip(pc);
    dec_allowin    = dec;
    flush          = fl;
    br_taken       = br;
    resetn         = rn;
    #1;
    m_allow = rn && (m_count != DEPTH);
    m_valid = rn && (m_count != 0) && !fl && !br;
    chk("id_allowin", 64'(id_allowin), 64'(m_allow));
    chk("iq_valid",   64'(iq_valid),   64'(m_valid));
    chk("iq_count",   64'(iq_count),   64'(m_count));
    obs_allow = id_allowin;
    obs_valid = iq_valid;
    obs_count = int'(iq_count);
    m_pop = m_valid && dec;
    if (m_pop) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_zip = sb.pop_front();
        chk("iq_zip", iq_zip, exp_zip);
        $display("pop  pc=0x%08h zip=0x%016h", exp_zip[31:0], iq_zip);
      end
    end
    m_push = v && m_allow && !fl && !br;
    if (!rn || fl || br) begin
      sb.delete();
      m_count = 0;
    end else begin
      if (m_push) begin
        sb.push_back(mk_zip(pc));
        $display("push pc=0x%08h count_before=%0d", pc, m_count);
      end
      m_count = m_count + int'(m_push) - int'(m_pop);
    end
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; br_taken = 1'b0;
    if_to_id_valid = 1'b0; if_to_id_zip = '0; dec_allowin = 1'b0;
    repeat (3) @(posedge clk);

    // Fill to full with the 5th beat held, then drain in order.
    tbl[0]  = '{1'b1, 32'h1c000000, 1'b0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b1, 32'h1c000004, 1'b0, 1'b1, 1'b1, 1};
    tbl[2]  = '{1'b1, 32'h1c000008, 1'b0, 1'b1, 1'b1, 2};
    tbl[3]  = '{1'b1, 32'h1c00000c, 1'b0, 1'b1, 1'b1, 3};
    tbl[4]  = '{1'b1, 32'h1c000010, 1'b0, 1'b0, 1'b1, 4};
    tbl[5]  = '{1'b1, 32'h1c000010, 1'b0, 1'b0, 1'b1, 4};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 4};
    tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 3};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 0};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].dec, 1'b0, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_allow", i), 64'(obs_allow), 64'(tbl[i].exp_allow));
      chk($sformatf("tbl%0d_valid", i), 64'(obs_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_count", i), 64'(obs_count), 64'(tbl[i].exp_count));
    end

    // Streaming: occupancy settles at 1, every beat delivered once in order.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h1c001000 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b1);
      if (i > 0) chk("stream_count", 64'(obs_count), 64'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Wrap: 3 push, 3 pop, 4 push, 4 pop.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1c002000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1c003000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wrap_full", 64'(sb.size()), 64'd4);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Flush with a valid push and a ready decoder: nothing moves, queue empties.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1c004000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h1c00dead, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_valid", 64'(obs_valid), 64'd0);
    step(1'b1, 32'h1c005000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_count", 64'(obs_count), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Branch redirect behaves like flush.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h1c006000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h1c00beef, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("br_valid", 64'(obs_valid), 64'd0);
    step(1'b1, 32'h1c007000, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("br_count", 64'(obs_count), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-run with two entries held.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h1c008000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h1c00ffff, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_allow_low", 64'(obs_allow), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_allow", 64'(obs_allow), 64'd1);
    chk("rst_valid", 64'(obs_valid), 64'd0);
    chk("rst_count", 64'(obs_count), 64'd0);
    step(1'b1, 32'h1c009000, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
